// File: rtl/bayer_pattern_generator_if.sv
// rtl/bayer_pattern_generator_if.sv - Bayer video stream bundle (pixel, line/frame framing, busy); frame_count_out with BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
interface bayer_pattern_generator_if;
    logic [9:0]  pixel_data_out;
    logic        line_valid_out;
    logic        frame_valid_out;
    logic        busy_out;
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
    logic [15:0] frame_count_out;

    modport master (
        output pixel_data_out,
        output line_valid_out,
        output frame_valid_out,
        output busy_out,
        output frame_count_out
    );

    modport slave (
        input pixel_data_out,
        input line_valid_out,
        input frame_valid_out,
        input busy_out,
        input frame_count_out
    );
`else
    modport master (
        output pixel_data_out,
        output line_valid_out,
        output frame_valid_out,
        output busy_out
    );

    modport slave (
        input pixel_data_out,
        input line_valid_out,
        input frame_valid_out,
        input busy_out
    );
`endif
endinterface

// File: rtl/bayer_pattern_generator.sv
// rtl/bayer_pattern_generator.sv - RAW10 Bayer test-pattern transmitter; optional frame counter via BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
module bayer_pattern_generator #(
    parameter int IMAGE_WIDTH  = 728,
    parameter int IMAGE_HEIGHT = 728,
    parameter int BAR_WIDTH    = 91,
    parameter int H_BLANK      = 32,
    parameter int FRONT_PORCH  = 8,
    parameter int BACK_PORCH   = 8,
    parameter int V_BLANK      = 64
) (
    input  logic       pixel_clock_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic [1:0] pattern_select_in,
    input  logic [9:0] solid_red_in,
    input  logic [9:0] solid_green_in,
    input  logic [9:0] solid_blue_in,
    bayer_pattern_generator_if.master video
);

    // One shared phase counter serves every state; it doubles as x in LINE.
    // Its width covers the longest phase and always at least 11 bits of x.
    localparam int M_A     = (IMAGE_WIDTH > H_BLANK) ? IMAGE_WIDTH : H_BLANK;
    localparam int M_B     = (FRONT_PORCH > BACK_PORCH) ? FRONT_PORCH : BACK_PORCH;
    localparam int M_C     = (V_BLANK > 2048) ? V_BLANK : 2048;
    localparam int M_AB    = (M_A > M_B) ? M_A : M_B;
    localparam int MAX_LEN = (M_AB > M_C) ? M_AB : M_C;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int Y_W     = 11;
    localparam int BAR_W   = $clog2(BAR_WIDTH + 1);

    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRONT_PORCH - 1);
    localparam logic [CNT_W-1:0] BP_LAST = CNT_W'(BACK_PORCH - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);
    localparam logic [Y_W-1:0]   H_LAST  = Y_W'(IMAGE_HEIGHT - 1);
    localparam logic [BAR_W-1:0] B_LAST  = BAR_W'(BAR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBLANK,
        S_BACK,
        S_VBLANK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [BAR_W-1:0] bar_sub_q, bar_sub_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic             load_cfg;

    logic [1:0]       pattern_q;
    logic [9:0]       red_q, green_q, blue_q;

    logic [2:0]       bar_rgb;
    logic [9:0]       ch_r, ch_g, ch_b;
    logic [9:0]       pixel_d;
    logic             frame_valid_d;
    logic             line_valid_d;
    logic             busy_d;

`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
    logic [15:0]      frame_count_q;
`endif

    // State register.
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next counter values; the outputs below are registered
    // from these so pixel data and framing line up with the same x,y.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        y_d       = y_q;
        bar_sub_d = bar_sub_q;
        bar_idx_d = bar_idx_q;
        load_cfg  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable_in) begin
                    state_d  = S_FRONT;
                    load_cfg = 1'b1;
                    y_d      = '0;
                end
            end
            S_FRONT: begin
                if (cnt_q == FP_LAST) begin
                    state_d   = S_LINE;
                    cnt_d     = '0;
                    bar_sub_d = '0;
                    bar_idx_d = '0;
                end
            end
            S_LINE: begin
                // Bar index steps once per BAR_WIDTH pixels and sticks at 7,
                // so the last bar absorbs any remainder of the line.
                if (bar_sub_q == B_LAST) begin
                    bar_sub_d = '0;
                    if (bar_idx_q != 3'd7) begin
                        bar_idx_d = bar_idx_q + 3'd1;
                    end
                end else begin
                    bar_sub_d = bar_sub_q + BAR_W'(1);
                end
                if (cnt_q == W_LAST) begin
                    cnt_d = '0;
                    if (y_q == H_LAST) begin
                        state_d = S_BACK;
                    end else begin
                        state_d = S_HBLANK;
                        y_d     = y_q + Y_W'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d   = S_LINE;
                    cnt_d     = '0;
                    bar_sub_d = '0;
                    bar_idx_d = '0;
                end
            end
            S_BACK: begin
                if (cnt_q == BP_LAST) begin
                    state_d = S_VBLANK;
                    cnt_d   = '0;
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    if (enable_in) begin
                        state_d  = S_FRONT;
                        load_cfg = 1'b1;
                        y_d      = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Position counters.
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            cnt_q     <= '0;
            y_q       <= '0;
            bar_sub_q <= '0;
            bar_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            bar_sub_q <= bar_sub_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern configuration is captured only at frame start so a frame is
    // never a mix of two patterns.
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            pattern_q <= 2'd0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else if (load_cfg) begin
            pattern_q <= pattern_select_in;
            red_q     <= solid_red_in;
            green_q   <= solid_green_in;
            blue_q    <= solid_blue_in;
        end
    end

    // Colour bar table, order white..black, bits are {R,G,B}.
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx_d)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    // Per-channel pattern value, then the Bayer mosaic picks one channel.
    always_comb begin
        ch_r    = '0;
        ch_g    = '0;
        ch_b    = '0;
        pixel_d = '0;
        case (pattern_q)
            2'd0: begin
                ch_r = {10{bar_rgb[2]}};
                ch_g = {10{bar_rgb[1]}};
                ch_b = {10{bar_rgb[0]}};
            end
            2'd1: begin
                ch_r = red_q;
                ch_g = green_q;
                ch_b = blue_q;
            end
            2'd2: begin
                ch_r = cnt_d[9:0];
                ch_g = cnt_d[9:0];
                ch_b = cnt_d[9:0];
            end
            default: begin
                ch_r = {10{cnt_d[4] ^ y_d[4]}};
                ch_g = {10{cnt_d[4] ^ y_d[4]}};
                ch_b = {10{cnt_d[4] ^ y_d[4]}};
            end
        endcase
        if (state_d == S_LINE) begin
            case ({y_d[0], cnt_d[0]})
                2'b00:   pixel_d = ch_b;
                2'b01:   pixel_d = ch_g;
                2'b10:   pixel_d = ch_g;
                default: pixel_d = ch_r;
            endcase
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
            // Stamp the frame number into the first pixel of each frame.
            if ((cnt_d == '0) && (y_d == '0)) begin
                pixel_d = frame_count_q[9:0];
            end
`endif
        end
    end

    // Framing flags derived from the state being entered.
    always_comb begin
        line_valid_d  = (state_d == S_LINE);
        frame_valid_d = (state_d == S_FRONT) || (state_d == S_LINE) ||
                        (state_d == S_HBLANK) || (state_d == S_BACK);
        busy_d        = (state_d != S_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            video.pixel_data_out  <= '0;
            video.line_valid_out  <= 1'b0;
            video.frame_valid_out <= 1'b0;
            video.busy_out        <= 1'b0;
        end else begin
            video.pixel_data_out  <= pixel_d;
            video.line_valid_out  <= line_valid_d;
            video.frame_valid_out <= frame_valid_d;
            video.busy_out        <= busy_d;
        end
    end

`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
    // Count completed frames on the frame_valid falling edge.
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            frame_count_q <= '0;
        end else if (video.frame_valid_out && !frame_valid_d) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign video.frame_count_out = frame_count_q;
`endif

endmodule

// File: tb/tb_bayer_pattern_generator.sv
// tb/tb_bayer_pattern_generator.sv - directed bench for bayer_pattern_generator
module tb_bayer_pattern_generator;

    localparam int W      = 16;
    localparam int H      = 4;
    localparam int BW     = 2;
    localparam int HB     = 2;
    localparam int FP     = 3;
    localparam int BP     = 3;
    localparam int VB     = 5;
    localparam int LINE_P = W + HB;              // 18
    localparam int ACT    = H * LINE_P - HB;     // 70
    localparam int FV_LEN = FP + ACT + BP;       // 76
    localparam int PERIOD = FV_LEN + VB;         // 81
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
    localparam bit FC_EN  = 1'b1;
`else
    localparam bit FC_EN  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [9:0] sr = '0;
    logic [9:0] sg = '0;
    logic [9:0] sb = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] row1_exp [16] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                                  10'h3FF, 10'h000, 10'h3FF, 10'h000,
                                  10'h000, 10'h3FF, 10'h000, 10'h3FF,
                                  10'h000, 10'h000, 10'h000, 10'h000};

    bayer_pattern_generator_if vif ();

    bayer_pattern_generator #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .BAR_WIDTH   (BW),
        .H_BLANK     (HB),
        .FRONT_PORCH (FP),
        .BACK_PORCH  (BP),
        .V_BLANK     (VB)
    ) dut (
        .pixel_clock_in   (clk),
        .reset_in         (reset),
        .enable_in        (enable),
        .pattern_select_in(pattern),
        .solid_red_in     (sr),
        .solid_green_in   (sg),
        .solid_blue_in    (sb),
        .video            (vif)
    );

    always #5 clk = ~clk;

    // t counts negedges after the edge that took the FSM out of IDLE.
    function automatic bit m_fv(int t);
        return (t % PERIOD) < FV_LEN;
    endfunction

    function automatic bit m_lv(int t);
        int r;
        r = (t % PERIOD) - FP;
        if (r < 0 || r >= ACT) return 1'b0;
        return (r % LINE_P) < W;
    endfunction

    function automatic int m_fc(int t);
        return t / PERIOD + (((t % PERIOD) >= FV_LEN) ? 1 : 0);
    endfunction

    function automatic logic [9:0] exp_pix(int p, int x, int y, int f);
        logic [2:0] rgb;
        logic [9:0] cr, cg, cb;
        int bar;
        if (FC_EN && x == 0 && y == 0) return 10'(f);
        bar = x / BW;
        if (bar > 7) bar = 7;
        case (bar)
            0: rgb = 3'b111;
            1: rgb = 3'b110;
            2: rgb = 3'b011;
            3: rgb = 3'b010;
            4: rgb = 3'b101;
            5: rgb = 3'b100;
            6: rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        case (p)
            0: begin
                cr = rgb[2] ? 10'h3FF : 10'h000;
                cg = rgb[1] ? 10'h3FF : 10'h000;
                cb = rgb[0] ? 10'h3FF : 10'h000;
            end
            1: begin cr = sr; cg = sg; cb = sb; end
            2: begin cr = 10'(x % 1024); cg = cr; cb = cr; end
            default: begin
                cr = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 10'h3FF : 10'h000;
                cg = cr;
                cb = cr;
            end
        endcase
        if (y % 2 == 0) return (x % 2 == 0) ? cb : cg;
        return (x % 2 == 0) ? cg : cr;
    endfunction

    function automatic logic [9:0] m_pix(int t, int p);
        int r;
        if (!m_lv(t)) return 10'd0;
        r = (t % PERIOD) - FP;
        return exp_pix(p, r % LINE_P, r / LINE_P, t / PERIOD);
    endfunction

    task automatic start_run(input logic [1:0] p, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pattern = p;
        sr = r;
        sg = g;
        sb = b;
        enable = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (vif.frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset.fv got %b want 0", vif.frame_valid_out); end
        vectors++; if (vif.line_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset.lv got %b want 0", vif.line_valid_out); end
        vectors++; if (vif.pixel_data_out !== 10'd0) begin miscompares++; $display("FAIL reset.pix got %h want 000", vif.pixel_data_out); end
        vectors++; if (vif.busy_out !== 1'b0) begin miscompares++; $display("FAIL reset.busy got %b want 0", vif.busy_out); end
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
        vectors++; if (vif.frame_count_out !== 16'd0) begin miscompares++; $display("FAIL reset.fc got %h want 0000", vif.frame_count_out); end
`endif
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (vif.busy_out !== 1'b0) begin miscompares++; $display("FAIL idle.busy got %b want 0", vif.busy_out); end
        vectors++; if (vif.frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL idle.fv got %b want 0", vif.frame_valid_out); end
    endtask

    task automatic test_timing_mosaic;
        int pulses = 0;
        int run = 0;
        int max_run = 0;
        int fv_cnt = 0;
        bit prev_lv = 1'b0;
        start_run(2'd1, 10'h100, 10'h200, 10'h300);
        for (int t = 0; t < 2 * PERIOD + 3; t++) begin
            @(negedge clk);
            vectors++; if (vif.frame_valid_out !== m_fv(t)) begin miscompares++; $display("FAIL timing.fv t=%0d got %b want %b", t, vif.frame_valid_out, m_fv(t)); end
            vectors++; if (vif.line_valid_out !== m_lv(t)) begin miscompares++; $display("FAIL timing.lv t=%0d got %b want %b", t, vif.line_valid_out, m_lv(t)); end
            vectors++; if (vif.busy_out !== 1'b1) begin miscompares++; $display("FAIL timing.busy t=%0d got %b want 1", t, vif.busy_out); end
            vectors++; if (vif.pixel_data_out !== m_pix(t, 1)) begin miscompares++; $display("FAIL timing.pix t=%0d got %h want %h", t, vif.pixel_data_out, m_pix(t, 1)); end
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
            vectors++; if (vif.frame_count_out !== 16'(m_fc(t))) begin miscompares++; $display("FAIL timing.fc t=%0d got %0d want %0d", t, vif.frame_count_out, m_fc(t)); end
`else
            if (t == FP) begin
                vectors++; if (vif.pixel_data_out !== 10'h300) begin miscompares++; $display("FAIL mosaic.r0x0 got %h want 300", vif.pixel_data_out); end
            end
`endif
            if (t == FP + 1) begin
                vectors++; if (vif.pixel_data_out !== 10'h200) begin miscompares++; $display("FAIL mosaic.r0x1 got %h want 200", vif.pixel_data_out); end
            end
            if (t == FP + LINE_P) begin
                vectors++; if (vif.pixel_data_out !== 10'h200) begin miscompares++; $display("FAIL mosaic.r1x0 got %h want 200", vif.pixel_data_out); end
            end
            if (t == FP + LINE_P + 1) begin
                vectors++; if (vif.pixel_data_out !== 10'h100) begin miscompares++; $display("FAIL mosaic.r1x1 got %h want 100", vif.pixel_data_out); end
            end
            if (t < PERIOD) begin
                if (vif.line_valid_out === 1'b1 && !prev_lv) pulses++;
                if (vif.line_valid_out === 1'b1) run++; else run = 0;
                if (run > max_run) max_run = run;
                if (vif.frame_valid_out === 1'b1) fv_cnt++;
                prev_lv = (vif.line_valid_out === 1'b1);
            end
        end
        vectors++; if (pulses !== 4) begin miscompares++; $display("FAIL timing.pulses got %0d want 4", pulses); end
        vectors++; if (max_run !== 16) begin miscompares++; $display("FAIL timing.line_len got %0d want 16", max_run); end
        vectors++; if (fv_cnt !== 76) begin miscompares++; $display("FAIL timing.fv_len got %0d want 76", fv_cnt); end
    endtask

    task automatic test_bars;
        start_run(2'd0, 10'h000, 10'h000, 10'h000);
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge clk);
            vectors++; if (vif.pixel_data_out !== m_pix(t, 0)) begin miscompares++; $display("FAIL bars.pix t=%0d got %h want %h", t, vif.pixel_data_out, m_pix(t, 0)); end
            if (t >= FP + LINE_P && t < FP + LINE_P + W) begin
                vectors++; if (vif.pixel_data_out !== row1_exp[t - FP - LINE_P]) begin miscompares++; $display("FAIL bars.row1 x=%0d got %h want %h", t - FP - LINE_P, vif.pixel_data_out, row1_exp[t - FP - LINE_P]); end
            end
        end
    endtask

    task automatic test_patterns;
        for (int p = 2; p < 4; p++) begin
            start_run(2'(p), 10'h000, 10'h000, 10'h000);
            for (int t = 0; t < PERIOD; t++) begin
                @(negedge clk);
                vectors++; if (vif.pixel_data_out !== m_pix(t, p)) begin miscompares++; $display("FAIL pattern%0d.pix t=%0d got %h want %h", p, t, vif.pixel_data_out, m_pix(t, p)); end
            end
        end
    endtask

    task automatic test_enable_drop;
        start_run(2'd1, 10'h155, 10'h0AA, 10'h3C3);
        for (int t = 0; t < PERIOD + 20; t++) begin
            @(negedge clk);
            if (t < PERIOD) begin
                vectors++; if (vif.frame_valid_out !== m_fv(t)) begin miscompares++; $display("FAIL drop.fv t=%0d got %b want %b", t, vif.frame_valid_out, m_fv(t)); end
                vectors++; if (vif.pixel_data_out !== m_pix(t, 1)) begin miscompares++; $display("FAIL drop.pix t=%0d got %h want %h", t, vif.pixel_data_out, m_pix(t, 1)); end
                vectors++; if (vif.busy_out !== 1'b1) begin miscompares++; $display("FAIL drop.busy t=%0d got %b want 1", t, vif.busy_out); end
            end else begin
                vectors++; if (vif.frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL drop.idle_fv t=%0d got %b want 0", t, vif.frame_valid_out); end
                vectors++; if (vif.busy_out !== 1'b0) begin miscompares++; $display("FAIL drop.idle_busy t=%0d got %b want 0", t, vif.busy_out); end
            end
            if (t == FP + 2 * LINE_P + 1) begin
                enable = 1'b0;
                pattern = 2'd2;
            end
        end
    endtask

    task automatic test_reset_mid;
        start_run(2'd1, 10'h011, 10'h022, 10'h033);
        for (int t = 0; t <= FP + 2 * LINE_P + 1; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (vif.frame_valid_out !== 1'b0) begin miscompares++; $display("FAIL rstmid.fv got %b want 0", vif.frame_valid_out); end
        vectors++; if (vif.line_valid_out !== 1'b0) begin miscompares++; $display("FAIL rstmid.lv got %b want 0", vif.line_valid_out); end
        vectors++; if (vif.pixel_data_out !== 10'd0) begin miscompares++; $display("FAIL rstmid.pix got %h want 000", vif.pixel_data_out); end
        vectors++; if (vif.busy_out !== 1'b0) begin miscompares++; $display("FAIL rstmid.busy got %b want 0", vif.busy_out); end
        reset = 1'b0;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge clk);
            vectors++; if (vif.frame_valid_out !== m_fv(t)) begin miscompares++; $display("FAIL rerun.fv t=%0d got %b want %b", t, vif.frame_valid_out, m_fv(t)); end
            vectors++; if (vif.line_valid_out !== m_lv(t)) begin miscompares++; $display("FAIL rerun.lv t=%0d got %b want %b", t, vif.line_valid_out, m_lv(t)); end
            vectors++; if (vif.pixel_data_out !== m_pix(t, 1)) begin miscompares++; $display("FAIL rerun.pix t=%0d got %h want %h", t, vif.pixel_data_out, m_pix(t, 1)); end
        end
    endtask

`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
    task automatic test_frame_counter;
        start_run(2'd1, 10'h3FF, 10'h3FF, 10'h3FF);
        for (int t = 0; t <= 3 * PERIOD + FP; t++) begin
            @(negedge clk);
            if (t == 3 * PERIOD) begin
                vectors++; if (vif.frame_count_out !== 16'd3) begin miscompares++; $display("FAIL fc.count got %0d want 3", vif.frame_count_out); end
            end
            if (t == 3 * PERIOD + FP) begin
                vectors++; if (vif.line_valid_out !== 1'b1) begin miscompares++; $display("FAIL fc.lv got %b want 1", vif.line_valid_out); end
                vectors++; if (vif.pixel_data_out !== 10'h003) begin miscompares++; $display("FAIL fc.stamp got %h want 003", vif.pixel_data_out); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timing_mosaic();
        test_bars();
        test_patterns();
        test_enable_drop();
        test_reset_mid();
`ifdef BAYER_PATTERN_GENERATOR_FRAME_COUNTER_EN
        test_frame_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
